// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU load/store
// port and the I/O block-transfer engine. The CPU wins every cycle unless the
// I/O side has been denied STARVE cycles in a row, in which case I/O is forced
// through. I/O transfers are word-sequential bursts started by a pulse.
module dmem_arbiter #(
    parameter int LEN_W  = 12,
    parameter int STARVE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wd,
    output logic [31:0]      cpu_rd,
    output logic             cpu_stall,
    input  logic             io_start,
    input  logic             io_dir,
    input  logic [31:0]      io_base,
    input  logic [LEN_W-1:0] io_len,
    input  logic             io_valid,
    input  logic [31:0]      io_wd,
    output logic [31:0]      io_rd,
    output logic             io_ack,
    output logic             io_busy,
    output logic             io_done,
    output logic             ram_we,
    output logic [31:0]      ram_addr,
    output logic [31:0]      ram_wd,
    input  logic [31:0]      ram_rd
);

    // Denial counter only ever needs to reach STARVE before a grant is forced.
    localparam int WC_W = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [WC_W-1:0] STARVE_LIM = WC_W'(STARVE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [LEN_W-1:0]  idx_r, idx_s;
    logic [LEN_W-1:0]  len_r, len_s;
    logic [WC_W-1:0]   wait_cnt_r, wait_cnt_s;
    logic [31:0]       base_r, base_s;
    logic              dir_r, dir_s;
    logic              io_want_s;
    logic              grant_io_s;
    logic [31:0]       io_addr_s;

    // State and transfer-context registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            len_r      <= '0;
            wait_cnt_r <= '0;
            base_r     <= 32'h0000_0000;
            dir_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            len_r      <= len_s;
            wait_cnt_r <= wait_cnt_s;
            base_r     <= base_s;
            dir_r      <= dir_s;
        end
    end

    // Next-state logic: start handling, grant decision, word index and starvation count.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        len_s      = len_r;
        wait_cnt_s = wait_cnt_r;
        base_s     = base_r;
        dir_s      = dir_r;
        io_want_s  = 1'b0;
        grant_io_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (io_start) begin
                    if (io_len != '0) begin
                        base_s     = io_base;
                        len_s      = io_len;
                        dir_s      = io_dir;
                        idx_s      = '0;
                        wait_cnt_s = '0;
                        state_s    = XFER;
                    end else begin
                        // Empty transfer completes without touching the RAM.
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            XFER: begin
                // Reads are always ready; writes need data from the I/O side.
                io_want_s  = ~dir_r | io_valid;
                grant_io_s = io_want_s & (~cpu_req | (wait_cnt_r == STARVE_LIM));
                if (grant_io_s) begin
                    idx_s      = idx_r + LEN_W'(1);
                    wait_cnt_s = '0;
                    if (idx_r == (len_r - LEN_W'(1))) begin
                        state_s = DONE;
                    end else begin
                        state_s = XFER;
                    end
                end else if (io_want_s) begin
                    wait_cnt_s = wait_cnt_r + WC_W'(1);
                end else begin
                    wait_cnt_s = '0;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Word address of the current I/O beat; wraps modulo 2^32.
    assign io_addr_s = base_r + (32'(idx_r) << 2);

    // RAM port steering: the granted I/O beat overrides the CPU access.
    always_comb begin
        ram_addr = cpu_addr;
        ram_we   = cpu_req & cpu_we;
        ram_wd   = cpu_wd;
        if (grant_io_s) begin
            ram_addr = io_addr_s;
            ram_we   = dir_r;
            ram_wd   = io_wd;
        end else begin
            ram_addr = cpu_addr;
            ram_we   = cpu_req & cpu_we;
            ram_wd   = cpu_wd;
        end
    end

    // Reads have no side effects, so both consumers see the RAM data directly.
    assign cpu_rd    = ram_rd;
    assign io_rd     = ram_rd;
    assign cpu_stall = cpu_req & grant_io_s;
    assign io_ack    = grant_io_s;
    assign io_busy   = (state_r != IDLE);
    assign io_done   = (state_r == DONE);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and transfer sequencer for the single-port data RAM. It shares the RAM between the processor load/store port and the I/O block-transfer engine. I/O transfers are word-sequential bursts started by a pulse. The CPU has priority on every cycle, and a starvation counter guarantees the I/O side a slot after a fixed number of denied cycles. It sits between the core's memory stage, the I/O controller and the data RAM, and drives the RAM's clk-synchronous write and combinational read ports.

## Interface
- LEN_W, 12, width of the transfer length in words.
- STARVE, 4, number of consecutive denied I/O cycles before the I/O side is forced a grant (≥1).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- cpu_req  in  1  CPU memory access this cycle.
- cpu_we  in  1  CPU write enable (qualified by cpu_req).
- cpu_addr  in  32  CPU byte address.
- cpu_wd  in  32  CPU write data.
- cpu_rd  out  32  read data to CPU (= ram_rd, combinational).
- cpu_stall  out  1  CPU access not performed this cycle; the core must hold its instruction.
- io_start  in  1  one-cycle pulse; starts a transfer (accepted only in IDLE).
- io_dir  in  1  1 = write into RAM, 0 = read from RAM; latched at start.
- io_base  in  32  byte start address; latched at start.
- io_len  in  LEN_W  transfer length in words; latched at start.
- io_valid  in  1  write data io_wd available (write direction only).
- io_wd  in  32  I/O write data.
- io_rd  out  32  I/O read data (= ram_rd).
- io_ack  out  1  I/O slot granted this cycle: a word was read (io_rd valid) or io_wd was consumed.
- io_busy  out  1  transfer in progress (state ≠ IDLE).
- io_done  out  1  one-cycle completion pulse.
- ram_we  out  1  to RAM write enable.
- ram_addr  out  32  to RAM byte address.
- ram_wd  out  32  to RAM write data.
- ram_rd  in  32  from RAM read data (asynchronous read).

## Operation
- States: IDLE, XFER, DONE.
- IDLE:
  - io_start=1 with io_len≠0: latch base, len and dir; idx←0; wait_cnt←0; go to XFER.
  - io_start=1 with io_len=0: go directly to DONE.
- XFER:
  - io_want = (dir=0) | (dir=1 & io_valid).
  - grant_io = io_want & (~cpu_req | wait_cnt==STARVE).
  - On grant_io: idx←idx+1 and wait_cnt←0. If idx==len−1, go to DONE.
  - On io_want & ~grant_io: wait_cnt←wait_cnt+1.
  - On ~io_want: wait_cnt←0.
- DONE: io_done=1 for one cycle, then go to IDLE.
- io_start in XFER or DONE is ignored; no queueing.
- RAM mux (combinational):
  - When grant_io: ram_addr = base + 4·idx (32-bit, wraps modulo 2^32), ram_we = dir, ram_wd = io_wd.
  - Otherwise: ram_addr = cpu_addr, ram_we = cpu_req & cpu_we, ram_wd = cpu_wd.
- cpu_stall = cpu_req & grant_io. io_ack = grant_io.
- A read never has side effects, so cpu_rd and io_rd are always ram_rd. Consumers qualify the data with ~cpu_stall or io_ack respectively.
- No address range checking; the RAM decodes ram_addr[13:2].

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, idx=0, wait_cnt=0, latched regs=0.
  - Resulting outputs: io_busy=0, io_done=0, io_ack=0, cpu_stall=0; RAM port follows the CPU.
- Reset mid-XFER aborts the transfer with no io_done pulse. RAM contents already written are kept.
- Latency:
  - io_start is sampled at edge 0; XFER is active from cycle 1, and the first grant is possible in cycle 1.
  - An uncontended transfer of N words acks in cycles 1..N, with io_done in cycle N+1 and io_busy=0 from cycle N+2.
- Writes take effect at the rising edge that ends the granted cycle.
- Under continuous cpu_req, I/O receives exactly 1 of every STARVE+1 cycles. The CPU is stalled only in those cycles.
- Simultaneous cpu_req and forced I/O grant: I/O wins, and the CPU is neither written nor acknowledged that cycle.
- cpu_req=0 during XFER: I/O is granted whenever io_want, every cycle.

## Test plan
- Reset mid-transfer: io_len=8 read, assert rst_n=0 after 3 acks → next cycle io_busy=0, io_done never pulses, idx=0; a fresh io_start then works.
- Uncontended read: RAM words 0..3 = 0xA0..0xA3, io_start with base=0, len=4, dir=0, cpu_req=0 → io_ack cycles 1–4 with io_rd=0xA0..0xA3, io_done in cycle 5, io_busy low in cycle 6.
- Starvation: STARVE=4, cpu_req=1 continuously, write base=0x20, len=3, io_valid=1 → io_ack in cycles 5, 10, 15; cpu_stall is high only in those cycles; RAM[8..10] = io_wd values.
- Write backpressure: dir=1, io_valid toggles 1,0,0,1 with cpu_req=0 → ack only when io_valid=1; wait_cnt stays 0; idx advances 2.
- Zero length and ignored start: io_len=0 → io_done next cycle with no RAM access; a second io_start during XFER → no change to base, len or idx.
- Address wrap: base=0xFFFF_FFFC, len=2 → ram_addr 0xFFFF_FFFC, then 0x0000_0000.
